// File: rtl/param_rotator_unit_pkg.sv
// Package rotator_pkg: shared encodings for the parametrised rotate/shift unit.
//   OP_*     command opcodes carried on cmd_op
//   DIR_*    direction encodings carried on cmd_dir
//   ST_*     controller state encodings
package rotator_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'd0;
  localparam op_t OP_ROT  = 2'd1;
  localparam op_t OP_SHL  = 2'd2;
  localparam op_t OP_SHA  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/param_rotator_unit_if.sv
// Command/data bundle between a control sequencer (master) and the rotator (slave).
//   cmd_valid/cmd_ready  command handshake, accept = valid & ready
//   cmd_op/dir/amt/count command fields, sampled at accept
//   data_in              LOAD operand
//   step_en              pacing for run steps
//   data_out/busy/done   register contents and status
interface param_rotator_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [AMT_W-1:0] cmd_amt;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] data_in;
  logic             step_en;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_amt, cmd_count, data_in, step_en,
    input  cmd_ready, data_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_amt, cmd_count, data_in, step_en,
    output cmd_ready, data_out, busy, done
  );
endinterface

// File: rtl/param_rotator_unit_step.sv
// rotator_step: combinational barrel stage applying one step to the data.
//   data      current register contents
//   op/dir    ROT, SHL or SHA in the given direction (SHA left behaves as SHL)
//   amt       positions moved; 0 leaves the data unchanged
//   next_data stepped data
//   carry     last bit moved out (only with ROTATOR_CARRY_EN defined)
module rotator_step
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
`ifdef ROTATOR_CARRY_EN
  output logic             carry,
`endif
  output logic [WIDTH-1:0] next_data
);

  localparam logic [AMT_W:0] W_L = WIDTH[AMT_W:0];

  logic [AMT_W:0]   back_amt;
  logic [WIDTH-1:0] wrap_hi;
  logic [WIDTH-1:0] wrap_lo;

  // Bits that wrap around on a rotate; a shift by WIDTH yields zero, so amt=0
  // contributes nothing. Their edge bit is also the last bit moved out.
  assign back_amt = W_L - {1'b0, amt};
  assign wrap_hi  = data >> back_amt;
  assign wrap_lo  = data << back_amt;

`ifdef ROTATOR_CARRY_EN
  assign carry = (dir == DIR_LEFT) ? wrap_hi[0] : wrap_lo[WIDTH-1];
`endif

  always_comb begin
    next_data = data;
    if (dir == DIR_LEFT) begin
      case (op)
        OP_ROT:         next_data = (data << amt) | wrap_hi;
        OP_SHL, OP_SHA: next_data = data << amt;
        default:        next_data = data;
      endcase
    end else begin
      case (op)
        OP_ROT:  next_data = (data >> amt) | wrap_lo;
        OP_SHL:  next_data = data >> amt;
        OP_SHA:  next_data = $signed(data) >>> amt;
        default: next_data = data;
      endcase
    end
  end

endmodule

// File: rtl/param_rotator_unit.sv
// param_rotator_unit: command-driven rotate/shift register with paced runs.
//   clk        clock
//   rst_n      synchronous active-low reset
//   bus        slave side of param_rotator_unit_if (commands in, data/status out)
//   carry_out  last bit moved out by a step; present only with ROTATOR_CARRY_EN
//
// state   | meaning
// ST_IDLE | waiting for a command; LOAD and zero-count commands finish here
// ST_RUN  | applying latched steps, one per cycle with step_en=1
module param_rotator_unit
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ROTATOR_CARRY_EN
  output logic carry_out,
`endif
  param_rotator_unit_if.slave bus
);

  logic [0:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       op_q;
  logic             dir_q;
  logic [AMT_W-1:0] amt_q;
  logic             done_q;
  logic [WIDTH-1:0] step_data;
  logic             accept;

`ifdef ROTATOR_CARRY_EN
  logic step_carry;
  logic carry_q;
  assign carry_out = carry_q;
`endif

  rotator_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
    .data      (data_q),
    .op        (op_q),
    .dir       (dir_q),
    .amt       (amt_q),
`ifdef ROTATOR_CARRY_EN
    .carry     (step_carry),
`endif
    .next_data (step_data)
  );

  assign bus.cmd_ready = (state == ST_IDLE) & rst_n;
  assign bus.busy      = (state == ST_RUN);
  assign bus.data_out  = data_q;
  assign bus.done      = done_q;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      remaining <= '0;
      op_q      <= OP_LOAD;
      dir_q     <= DIR_LEFT;
      amt_q     <= '0;
      done_q    <= 1'b0;
`ifdef ROTATOR_CARRY_EN
      carry_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.cmd_op == OP_LOAD) begin
              data_q  <= bus.data_in;
              done_q  <= 1'b1;
`ifdef ROTATOR_CARRY_EN
              carry_q <= 1'b0;
`endif
            end else if (bus.cmd_count == '0) begin
              done_q <= 1'b1;
            end else begin
              op_q      <= bus.cmd_op;
              dir_q     <= bus.cmd_dir;
              amt_q     <= bus.cmd_amt;
              remaining <= bus.cmd_count;
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.step_en) begin
            data_q    <= step_data;
`ifdef ROTATOR_CARRY_EN
            if (amt_q != '0) carry_q <= step_carry;
`endif
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_rotator_unit.sv
// Testbench for param_rotator_unit (WIDTH=8, CNT_W=8): directed cases followed by
// randomized commands, compared every cycle against a behavioural model.
module tb_param_rotator_unit;
  import rotator_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
`ifdef ROTATOR_CARRY_EN
  logic carry_out;
`endif

  param_rotator_unit_if #(.WIDTH(W), .AMT_W(AW), .CNT_W(CW)) bus ();

  param_rotator_unit #(.WIDTH(W), .AMT_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ROTATOR_CARRY_EN
    .carry_out (carry_out),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  logic [W-1:0] m_data  = '0;
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_carry = 1'b0;
  int           m_rem   = 0;
  logic [1:0]   m_op    = OP_LOAD;
  logic         m_dir   = DIR_LEFT;
  int           m_amt   = 0;
  logic         last_ready;
  int           busy_cycles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One step worked out bit by bit from where each result bit comes from.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] d, input logic [1:0] op,
                                             input logic dir, input int k);
    logic [W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (dir == DIR_LEFT) begin
        s = i - k;
        if (op == OP_ROT)  r[i] = d[(s + W) % W];
        else if (s >= 0)   r[i] = d[s];
        else               r[i] = 1'b0;
      end else begin
        s = i + k;
        if (op == OP_ROT)       r[i] = d[s % W];
        else if (s < W)         r[i] = d[s];
        else if (op == OP_SHA)  r[i] = d[W-1];
        else                    r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] d, input logic dir, input int k);
    if (dir == DIR_LEFT) return d[W-k];
    return d[k-1];
  endfunction

  task automatic model_update(input logic v, input logic [1:0] op, input logic dir,
                              input int amt, input int cnt, input logic [W-1:0] din,
                              input logic sen, input logic rn);
    if (!rn) begin
      m_busy = 1'b0; m_data = '0; m_done = 1'b0; m_rem = 0; m_carry = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (v) begin
        if (op == OP_LOAD) begin
          m_data = din; m_done = 1'b1; m_carry = 1'b0;
        end else if (cnt == 0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1; m_rem = cnt; m_op = op; m_dir = dir; m_amt = amt;
        end
      end
    end else begin
      m_done = 1'b0;
      if (sen) begin
        if (m_amt != 0) m_carry = ref_carry(m_data, m_dir, m_amt);
        m_data = ref_step(m_data, m_op, m_dir, m_amt);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check ready, clock, check outputs.
  task automatic cyc(input logic v, input logic [1:0] op, input logic dir, input int amt,
                     input int cnt, input logic [W-1:0] din, input logic sen, input logic rn);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_dir   = dir;
    bus.cmd_amt   = AW'(amt);
    bus.cmd_count = CW'(cnt);
    bus.data_in   = din;
    bus.step_en   = sen;
    rst_n         = rn;
    #1;
    last_ready = bus.cmd_ready;
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(rn & ~m_busy));
    model_update(v, op, dir, amt, cnt, din, sen, rn);
    @(posedge clk);
    @(negedge clk);
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
`ifdef ROTATOR_CARRY_EN
    chk("carry_out", 32'(carry_out), 32'(m_carry));
`endif
  endtask

  task automatic idle(input logic sen);
    cyc(1'b0, OP_LOAD, DIR_LEFT, 0, 0, '0, sen, 1'b1);
  endtask

  task automatic load(input logic [W-1:0] d);
    cyc(1'b1, OP_LOAD, DIR_LEFT, 0, 0, d, 1'b1, 1'b1);
  endtask

  task automatic cmd(input logic [1:0] op, input logic dir, input int amt, input int cnt);
    cyc(1'b1, op, dir, amt, cnt, '0, 1'b1, 1'b1);
  endtask

  logic sen_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_LOAD; bus.cmd_dir = DIR_LEFT;
    bus.cmd_amt = '0; bus.cmd_count = '0; bus.data_in = '0; bus.step_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    // reset
    cyc(1'b0, OP_LOAD, DIR_LEFT, 0, 0, '0, 1'b0, 1'b0);
    cyc(1'b0, OP_LOAD, DIR_LEFT, 0, 0, '0, 1'b0, 1'b0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // 1: rotate left by one, three steps
    load(8'h81);
    chk("t1_load", 32'(bus.data_out), 32'h81);
    cmd(OP_ROT, DIR_LEFT, 1, 3);
    chk("t1_accept_nostep", 32'(bus.data_out), 32'h81);
    busy_cycles = int'(bus.busy);
    idle(1'b1); chk("t1_s1", 32'(bus.data_out), 32'h03); busy_cycles += int'(bus.busy);
    idle(1'b1); chk("t1_s2", 32'(bus.data_out), 32'h06); busy_cycles += int'(bus.busy);
    idle(1'b1); chk("t1_s3", 32'(bus.data_out), 32'h0C); busy_cycles += int'(bus.busy);
    chk("t1_done", 32'(bus.done), 32'h1);
    chk("t1_busy_len", 32'(busy_cycles), 32'd3);
    idle(1'b1);
    chk("t1_done_pulse", 32'(bus.done), 32'h0);

    // 2: right rotate and the two right shift flavours
    load(8'h81); cmd(OP_ROT, DIR_RIGHT, 1, 1); idle(1'b1);
    chk("t2_rot_r", 32'(bus.data_out), 32'hC0);
    load(8'h90); cmd(OP_SHA, DIR_RIGHT, 2, 1); idle(1'b1);
    chk("t2_sha_r", 32'(bus.data_out), 32'hE4);
    load(8'h90); cmd(OP_SHL, DIR_RIGHT, 2, 1); idle(1'b1);
    chk("t2_shl_r", 32'(bus.data_out), 32'h24);

    // 3: paced run, commands offered while busy must be ignored
    load(8'h81); cmd(OP_ROT, DIR_LEFT, 1, 4);
    foreach (sen_pat[i]) cyc(1'b1, OP_LOAD, DIR_LEFT, 0, 0, 8'hFF, sen_pat[i], 1'b1);
    chk("t3_data", 32'(bus.data_out), 32'h18);
    chk("t3_done", 32'(bus.done), 32'h1);
    idle(1'b0);

    // 4: zero count and zero amount
    cmd(OP_ROT, DIR_LEFT, 1, 0);
    chk("t4_cnt0_done", 32'(bus.done), 32'h1);
    chk("t4_cnt0_busy", 32'(bus.busy), 32'h0);
    cmd(OP_SHL, DIR_RIGHT, 0, 2);
    idle(1'b1);
    chk("t4_amt0_mid", 32'(bus.done), 32'h0);
    idle(1'b1);
    chk("t4_amt0_data", 32'(bus.data_out), 32'h18);
    chk("t4_amt0_done", 32'(bus.done), 32'h1);

    // 5: reset in the middle of a run
    load(8'h81); cmd(OP_ROT, DIR_LEFT, 1, 4); idle(1'b1); idle(1'b1);
    cyc(1'b1, OP_LOAD, DIR_LEFT, 0, 0, 8'h5A, 1'b1, 1'b0);
    chk("t5_data", 32'(bus.data_out), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    idle(1'b1);
    chk("t5_ready", 32'(last_ready), 32'h1);
    chk("t5_no_done", 32'(bus.done), 32'h0);

`ifdef ROTATOR_CARRY_EN
    // 6: carry out
    load(8'h81); cmd(OP_ROT, DIR_LEFT, 1, 1); idle(1'b1);
    chk("t6_rot_data", 32'(bus.data_out), 32'h03);
    chk("t6_rot_carry", 32'(carry_out), 32'h1);
    cmd(OP_SHL, DIR_RIGHT, 1, 1); idle(1'b1);
    chk("t6_shl_data", 32'(bus.data_out), 32'h01);
    chk("t6_shl_carry", 32'(carry_out), 32'h1);
    load(8'h55);
    chk("t6_load_carry", 32'(carry_out), 32'h0);
`endif

    // randomized commands with random pacing and occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic       v, dir, sen, rn;
      logic [1:0] op;
      int         amt, cnt;
      logic [W-1:0] din;
      v   = ($urandom % 3) == 0;
      op  = 2'($urandom % 4);
      dir = 1'($urandom % 2);
      amt = int'($urandom % W);
      cnt = (($urandom % 4) == 0) ? 0 : int'($urandom_range(1, 6));
      din = W'($urandom);
      sen = ($urandom % 4) != 0;
      rn  = ($urandom % 80) != 0;
      cyc(v, op, dir, amt, cnt, din, sen, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
